cx_merge: RTL
=============

// Module: cx_merge
// PURPOSE
//  Two-input merge stage for the COPY stage token path, the converging end of the copy/exclusive-branch element.
//  Accepts tokens from two upstream Send/Ack channels and emits them one at a time on a single downstream channel.
//  Tags each output token with the input it came from, and counts completed tokens per source.
//  Clocked, synchronous model of the handshake; sits where copied or branched token streams rejoin the main pipe.
// PARAMETERS
//  DW  32  token data width
//  CW  8   width of each per-source token counter
// PORTS
//  CLK       in   1   clock, all state updates on rising edge
//  MR        in   1   master reset, asynchronous, active-high
//  Send_in0  in   1   request from upstream channel 0
//  Data_in0  in   DW  token data, channel 0; stable while Send_in0=1
//  Ack_out0  out  1   acknowledge to upstream channel 0
//  Send_in1  in   1   request from upstream channel 1
//  Data_in1  in   DW  token data, channel 1; stable while Send_in1=1
//  Ack_out1  out  1   acknowledge to upstream channel 1
//  Send_out  out  1   request to downstream
//  Data_out  out  DW  buffered token data
//  Src_out   out  1   source of the buffered token (0/1)
//  Ack_in    in   1   acknowledge from downstream
//  Busy      out  1   token buffer occupied
//  Cnt0      out  CW  completed output tokens from channel 0, saturating
//  Cnt1      out  CW  completed output tokens from channel 1, saturating
// BEHAVIOUR
//  Protocol (both sides): 4-phase return-to-zero.
//   - Send rises with data valid, then Ack rises, then Send falls, then Ack falls.
//  Storage: one-entry buffer (buf, src, full). All outputs are registered.
//  MR=1 (asynchronous):
//   - All outputs go to 0 immediately: Ack_out0/1, Send_out, Data_out, Src_out, Busy, Cnt0/1.
//   - full=0; last_gnt=1, so channel 0 wins the first tie.
//   - Both FSMs return to IDLE. A token in flight is dropped.
//  Input FSM, states I_IDLE and I_ACK:
//   - I_IDLE, full=0, one Send_inX=1: capture Data_inX into buf, src<=X, full<=1, Ack_outX<=1, go I_ACK.
//   - I_IDLE, full=0, both Send_in=1: grant the channel != last_gnt, then set last_gnt<=grant (round-robin).
//   - I_IDLE, full=1: no capture, Ack_out0/1 stay 0.
//   - I_ACK: hold Ack_outX=1 until Send_inX is sampled 0, then Ack_outX<=0, go I_IDLE.
//   - The other channel waits throughout; it is never acked while not granted.
//   - Send_inX dropping before it is sampled high has no effect.
//  Output FSM, states O_IDLE, O_REQ and O_RTZ:
//   - O_IDLE, full=1: Send_out<=1, Data_out<=buf, Src_out<=src, go O_REQ.
//   - O_REQ, Ack_in=1: Send_out<=0, go O_RTZ.
//   - O_RTZ, Ack_in=0: full<=0, increment Cnt[src] (saturate at 2^CW-1), go O_IDLE.
//   - Data_out/Src_out hold from Send_out rise until the next capture.
//   - Ack_in=1 in O_IDLE is ignored.
//  Busy = full.
//  Latency, with Send_inX sampled high at edge 0 and buffer empty:
//   - Ack_outX=1 after edge 0.
//   - Send_out=1 after edge 1.
//  Input and output handshakes overlap: the upstream RTZ may complete while the token is still downstream.
//  Back-to-back: full clears on the O_RTZ exit edge; the next capture happens at the earliest on the following edge.
//   - Steady-state throughput is therefore at most one token per 4 cycles plus the downstream Ack delay.
//  No token is ever duplicated or lost outside MR.
// TESTING
//  1. MR pulse mid-I_ACK, mid-O_REQ and mid-O_RTZ.
//     -> All outputs 0 within the same cycle; the next token on ch0 goes out with Src_out=0, and Cnt0=1 after its handshake.
//  2. Single token ch1, Data_in1=32'hDEADBEEF, downstream acks 1 cycle after Send_out.
//     -> Ack_out1 at +1 cycle, Send_out at +2, Data_out=DEADBEEF, Src_out=1, Cnt1=1 after RTZ.
//  3. Both Send_in high together after reset.
//     -> ch0 is served first, ch1 second.
//     -> Repeat with both high: ch1 first (round-robin). Outputs alternate 0,1,0,1 over 8 tokens; Cnt0=Cnt1=4.
//  4. Downstream holds Ack_in=0 for 20 cycles while ch0 sends 2 tokens.
//     -> The second token is not acked until the first completes RTZ; Busy=1 throughout; data order preserved.
//  5. CW=4, 20 tokens on ch0.
//     -> Cnt0 saturates at 15 and stays; Cnt1=0.
//  6. Random Send/Ack delays (0-5 cycles), 1000 tokens.
//     -> Scoreboard: output sequence equals the accepted sequence with correct Src_out; no 4-phase rule violated.

Source files
------------

// File: rtl/cx_merge.sv
// Two-input round-robin merge of 4-phase Send/Ack token channels into one source-tagged output channel.
// One-entry buffer; Ack_outX one edge after capture, Send_out one edge later; per-source saturating counters.
module cx_merge #(
  parameter int DW = 32,
  parameter int CW = 8
) (
  input  logic          CLK,
  input  logic          MR,
  input  logic          Send_in0,
  input  logic [DW-1:0] Data_in0,
  output logic          Ack_out0,
  input  logic          Send_in1,
  input  logic [DW-1:0] Data_in1,
  output logic          Ack_out1,
  output logic          Send_out,
  output logic [DW-1:0] Data_out,
  output logic          Src_out,
  input  logic          Ack_in,
  output logic          Busy,
  output logic [CW-1:0] Cnt0,
  output logic [CW-1:0] Cnt1
);

  typedef enum logic {I_IDLE, I_ACK} istate_t;
  typedef enum logic [1:0] {O_IDLE, O_REQ, O_RTZ} ostate_t;

  istate_t       ist_q, ist_d;
  ostate_t       ost_q, ost_d;
  logic          full_q, full_d;
  logic [DW-1:0] buf_q, buf_d;
  logic          src_q, src_d;
  logic          last_gnt_q, last_gnt_d;
  logic          gnt_q, gnt_d;
  logic          ack0_q, ack0_d, ack1_q, ack1_d;
  logic          send_q, send_d;
  logic [DW-1:0] dout_q, dout_d;
  logic          srco_q, srco_d;
  logic [CW-1:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;

  logic capture, gnt_sel, gnt_send, retire;

  // On a tie the channel that did not win the previous tie is served.
  assign gnt_sel  = (Send_in0 & Send_in1) ? ~last_gnt_q : Send_in1;
  assign capture  = (ist_q == I_IDLE) & ~full_q & (Send_in0 | Send_in1);
  assign gnt_send = gnt_q ? Send_in1 : Send_in0;
  assign retire   = (ost_q == O_RTZ) & ~Ack_in;

  always_ff @(posedge CLK or posedge MR) begin
    if (MR) begin
      ist_q      <= I_IDLE;
      ost_q      <= O_IDLE;
      full_q     <= 1'b0;
      buf_q      <= '0;
      src_q      <= 1'b0;
      last_gnt_q <= 1'b1;
      gnt_q      <= 1'b0;
      ack0_q     <= 1'b0;
      ack1_q     <= 1'b0;
      send_q     <= 1'b0;
      dout_q     <= '0;
      srco_q     <= 1'b0;
      cnt0_q     <= '0;
      cnt1_q     <= '0;
    end else begin
      ist_q      <= ist_d;
      ost_q      <= ost_d;
      full_q     <= full_d;
      buf_q      <= buf_d;
      src_q      <= src_d;
      last_gnt_q <= last_gnt_d;
      gnt_q      <= gnt_d;
      ack0_q     <= ack0_d;
      ack1_q     <= ack1_d;
      send_q     <= send_d;
      dout_q     <= dout_d;
      srco_q     <= srco_d;
      cnt0_q     <= cnt0_d;
      cnt1_q     <= cnt1_d;
    end
  end

  always_comb begin
    ist_d = ist_q;
    case (ist_q)
      I_IDLE:  if (capture) ist_d = I_ACK;
      I_ACK:   if (!gnt_send) ist_d = I_IDLE;
      default: ist_d = I_IDLE;
    endcase
    ost_d = ost_q;
    case (ost_q)
      O_IDLE:  if (full_q) ost_d = O_REQ;
      O_REQ:   if (Ack_in) ost_d = O_RTZ;
      O_RTZ:   if (!Ack_in) ost_d = O_IDLE;
      default: ost_d = O_IDLE;
    endcase
  end

  always_comb begin
    full_d     = full_q;
    buf_d      = buf_q;
    src_d      = src_q;
    last_gnt_d = last_gnt_q;
    gnt_d      = gnt_q;
    ack0_d     = ack0_q;
    ack1_d     = ack1_q;
    send_d     = send_q;
    dout_d     = dout_q;
    srco_d     = srco_q;
    cnt0_d     = cnt0_q;
    cnt1_d     = cnt1_q;
    if (capture) begin
      buf_d  = gnt_sel ? Data_in1 : Data_in0;
      src_d  = gnt_sel;
      gnt_d  = gnt_sel;
      full_d = 1'b1;
      ack0_d = ~gnt_sel;
      ack1_d = gnt_sel;
      if (Send_in0 & Send_in1) last_gnt_d = gnt_sel;
    end
    if ((ist_q == I_ACK) && !gnt_send) begin
      ack0_d = 1'b0;
      ack1_d = 1'b0;
    end
    if ((ost_q == O_IDLE) && full_q) begin
      send_d = 1'b1;
      dout_d = buf_q;
      srco_d = src_q;
    end
    if ((ost_q == O_REQ) && Ack_in) send_d = 1'b0;
    // Buffer frees only once downstream has returned to zero.
    if (retire) begin
      full_d = 1'b0;
      if (!src_q && (cnt0_q != {CW{1'b1}})) cnt0_d = cnt0_q + CW'(1);
      if (src_q && (cnt1_q != {CW{1'b1}})) cnt1_d = cnt1_q + CW'(1);
    end
  end

  assign Ack_out0 = ack0_q;
  assign Ack_out1 = ack1_q;
  assign Send_out = send_q;
  assign Data_out = dout_q;
  assign Src_out  = srco_q;
  assign Busy     = full_q;
  assign Cnt0     = cnt0_q;
  assign Cnt1     = cnt1_q;

endmodule
